// File: rtl/echo_timer.sv
// echo_timer: times an ultrasonic echo pulse after a trigger spike and reports
// its width in microseconds, or in centimetres when ECHO_TIMER_CM_EN is defined.
// Missing echoes and echoes longer than TIMEOUT_US report 16'hFFFF with timeout=1.
// Build option: define ECHO_TIMER_CM_EN to include the repeated-subtraction divider.
module echo_timer #(
  parameter int unsigned CLKS_PER_US = 6,
  parameter int unsigned TIMEOUT_US  = 30000,
  parameter int unsigned US_PER_CM   = 58
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic        echo,
  output logic [15:0] value,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  localparam logic [15:0] PSC_LAST = 16'(CLKS_PER_US - 1);
  localparam logic [15:0] TMO_US   = 16'(TIMEOUT_US);

`ifdef ECHO_TIMER_CM_EN
  localparam logic [15:0] DIV_CM = 16'(US_PER_CM);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_MEASURE = 3'd2,
    S_CONVERT = 3'd3,
    S_DONE    = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_MEASURE = 3'd2,
    S_DONE    = 3'd4
  } state_e;
`endif

  // Saturating 16-bit increment: counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    if (x == 16'hFFFF) begin
      return 16'hFFFF;
    end else begin
      return x + 16'd1;
    end
  endfunction

  state_e      state_q;
  logic        sync1_q, sync2_q, sync3_q;
  logic        rise_q, fall_q;
  logic        trig_q;
  logic [15:0] psc_q, us_q;
  logic [15:0] psc_d, us_d;
  logic [15:0] value_q;
  logic        valid_q, timeout_q, busy_q;
  logic        trig_fall_s;
`ifdef ECHO_TIMER_CM_EN
  logic [15:0] rem_q, quo_q;
`endif

  // trig is already synchronous, so one register is enough to see its falling edge.
  assign trig_fall_s = trig_q & ~trig;

  // Echo synchronizer, registered rise/fall pulses, and trig history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      sync1_q <= echo;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      rise_q  <= sync2_q & ~sync3_q;
      fall_q  <= ~sync2_q & sync3_q;
      trig_q  <= trig;
    end
  end

  // Prescaler and microsecond counter advanced by one clock.
  always_comb begin
    if (psc_q >= PSC_LAST) begin
      psc_d = 16'd0;
      us_d  = sat_inc(us_q);
    end else begin
      psc_d = psc_q + 16'd1;
      us_d  = us_q;
    end
  end

  // Control FSM with registered result, strobe and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      psc_q     <= 16'd0;
      us_q      <= 16'd0;
      value_q   <= 16'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ECHO_TIMER_CM_EN
      rem_q     <= 16'd0;
      quo_q     <= 16'd0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (trig_fall_s) begin
            state_q <= S_ARMED;
            psc_q   <= 16'd0;
            us_q    <= 16'd0;
            busy_q  <= 1'b1;
          end
        end
        S_ARMED: begin
          if (rise_q) begin
            state_q <= S_MEASURE;
            psc_q   <= 16'd0;
            us_q    <= 16'd0;
          end else if (us_q >= TMO_US) begin
            state_q   <= S_DONE;
            value_q   <= 16'hFFFF;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            psc_q <= psc_d;
            us_q  <= us_d;
          end
        end
        S_MEASURE: begin
          // The fall is checked first so a fall coinciding with timeout still measures.
          if (fall_q) begin
`ifdef ECHO_TIMER_CM_EN
            state_q <= S_CONVERT;
            rem_q   <= us_d;
            quo_q   <= 16'd0;
`else
            state_q   <= S_DONE;
            value_q   <= us_d;
            valid_q   <= 1'b1;
            timeout_q <= 1'b0;
`endif
          end else if (us_q >= TMO_US) begin
            state_q   <= S_DONE;
            value_q   <= 16'hFFFF;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            psc_q <= psc_d;
            us_q  <= us_d;
          end
        end
`ifdef ECHO_TIMER_CM_EN
        S_CONVERT: begin
          if (rem_q >= DIV_CM) begin
            rem_q <= rem_q - DIV_CM;
            quo_q <= sat_inc(quo_q);
          end else begin
            state_q   <= S_DONE;
            value_q   <= quo_q;
            valid_q   <= 1'b1;
            timeout_q <= 1'b0;
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign value   = value_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_echo_timer.sv
// Self-checking bench for echo_timer. Expected results come from the echo width
// in clocks: us = floor(width / CLKS_PER_US), optionally divided down to cm.
module tb_echo_timer;

  localparam int CLKS = 6;
  localparam int TMO  = 700;
  localparam int CM   = 58;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic        echo = 1'b0;
  logic [15:0] value;
  logic        valid;
  logic        timeout;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  echo_timer #(
    .CLKS_PER_US(CLKS),
    .TIMEOUT_US (TMO),
    .US_PER_CM  (CM)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .trig   (trig),
    .echo   (echo),
    .value  (value),
    .valid  (valid),
    .timeout(timeout),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: result and edges from the echo-fall drive until valid.
  function automatic void ref_model(input int width_clk, output int val, output int lat);
    int us;
    us = width_clk / CLKS;
`ifdef ECHO_TIMER_CM_EN
    val = us / CM;
    lat = val + 5;
`else
    val = us;
    lat = 4;
`endif
  endfunction

  task automatic trig_pulse();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
  endtask

  // One full measurement with an echo that is not a timeout.
  task automatic run_measure(input string tag, input int pre_us, input int width_clk, input bit retrig);
    int exp_val, exp_lat, lat;
    bit seen;
    ref_model(width_clk, exp_val, exp_lat);
    trig_pulse();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_trig got=%b want=1", tag, busy);
    else pass_cnt++;
    repeat (pre_us * CLKS) tick();
    echo = 1'b1;
    for (int i = 0; i < width_clk; i++) begin
      if (retrig && i == width_clk / 2) trig = 1'b1;
      if (retrig && i == width_clk / 2 + 1) trig = 1'b0;
      tick();
    end
    trig = 1'b0;
    echo = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < exp_lat + 40) begin
      tick();
      lat++;
      if (valid === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (!seen || lat != exp_lat)
      $display("FAIL %s latency got=%0d seen=%b want=%0d", tag, lat, seen, exp_lat);
    else pass_cnt++;
    total_cnt++;
    if (value !== 16'(exp_val)) $display("FAIL %s value got=%0d want=%0d", tag, value, exp_val);
    else pass_cnt++;
    total_cnt++;
    if (timeout !== 1'b0) $display("FAIL %s timeout got=%b want=0", tag, timeout);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s after_done valid=%b busy=%b want 0/0", tag, valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if (value !== 16'd0 || valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset got value=%0d valid=%b timeout=%b busy=%b want 0/0/0/0",
               value, valid, timeout, busy);
    else pass_cnt++;
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_basic();
    run_measure("cm_case_3480", 100, 3480, 1'b0);
  endtask

  task automatic test_no_echo_timeout();
    int lat;
    bit seen;
    trig_pulse();
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 6 * TMO + 50) begin
      tick();
      lat++;
      if (valid === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (!seen || lat != 6 * TMO + 1)
      $display("FAIL no_echo latency got=%0d seen=%b want=%0d", lat, seen, 6 * TMO + 1);
    else pass_cnt++;
    total_cnt++;
    if (value !== 16'hFFFF || timeout !== 1'b1)
      $display("FAIL no_echo result value=%h timeout=%b want ffff/1", value, timeout);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (valid !== 1'b0 || busy !== 1'b0 || timeout !== 1'b1)
      $display("FAIL no_echo after valid=%b busy=%b timeout=%b want 0/0/1", valid, busy, timeout);
    else pass_cnt++;
    run_measure("clear_after_timeout", 20, 1000, 1'b0);
  endtask

  task automatic test_long_echo();
    int lat, stray;
    bit seen;
    trig_pulse();
    echo = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 6 * TMO + 60) begin
      tick();
      lat++;
      if (valid === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (!seen || lat != 6 * TMO + 5)
      $display("FAIL long_echo latency got=%0d seen=%b want=%0d", lat, seen, 6 * TMO + 5);
    else pass_cnt++;
    total_cnt++;
    if (value !== 16'hFFFF || timeout !== 1'b1)
      $display("FAIL long_echo result value=%h timeout=%b want ffff/1", value, timeout);
    else pass_cnt++;
    repeat (6 * 50) tick();
    echo = 1'b0;
    stray = 0;
    repeat (20) begin
      tick();
      if (valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    total_cnt++;
    if (stray != 0 || value !== 16'hFFFF)
      $display("FAIL long_echo late_fall stray=%0d value=%h want 0/ffff", stray, value);
    else pass_cnt++;
    run_measure("after_long_echo", 10, 3480, 1'b0);
  endtask

  task automatic test_retrig();
    run_measure("retrig_ignored", 100, 3480, 1'b1);
  endtask

  task automatic test_boundary();
    run_measure("width_eq_timeout", 5, 6 * TMO, 1'b0);
    run_measure("fall_with_timeout", 5, 6 * TMO + 1, 1'b0);
    run_measure("width_one_clk", 5, 1, 1'b0);
  endtask

  task automatic test_mid_reset();
    int stray;
    trig_pulse();
    repeat (60) tick();
    echo = 1'b1;
    repeat (600) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || value !== 16'd0 || valid !== 1'b0 || timeout !== 1'b0)
      $display("FAIL mid_reset got busy=%b value=%0d valid=%b timeout=%b want 0/0/0/0",
               busy, value, valid, timeout);
    else pass_cnt++;
    repeat (100) tick();
    echo = 1'b0;
    stray = 0;
    repeat (20) begin
      tick();
      if (valid !== 1'b0) stray++;
    end
    total_cnt++;
    if (stray != 0) $display("FAIL mid_reset stray_valid got=%0d want=0", stray);
    else pass_cnt++;
    run_measure("after_mid_reset", 30, 2000, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_measure($sformatf("random_%0d", k), int'($urandom_range(0, 50)),
                  int'($urandom_range(1, 6 * TMO - 100)), 1'(k % 2));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_echo_timeout();
    test_long_echo();
    test_retrig();
    test_boundary();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
